// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage.
// Owns the program counter, presents it as the instruction-memory byte address,
// and registers the returned word plus its PC into the IF/ID register.
// Handles start/halt sequencing, stalls, branch/jump redirects (which insert a
// bubble) and a saturating count of captured instructions.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             level; leaves IDLE
//   stall             hold PC and IF/ID this cycle
//   br_taken, jmp_en  redirect requests (branch wins when both are high)
//   redir_pc4         PC+4 of the redirecting instruction
//   br_imm            signed word offset for branches
//   jmp_idx           26-bit jump index
//   inst_addr         byte address to instruction memory (= pc)
//   inst              instruction word for inst_addr, same cycle
//   id_pc, id_pc4     PC / PC+4 of the IF/ID instruction
//   id_inst, id_valid IF/ID instruction and its valid flag
//   fetch_cnt         saturating count of valid captures
//   halted            high once the fetch has reached HALT
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_LIMIT = 32'h0000_0024,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stall,
   input  logic             br_taken,
   input  logic             jmp_en,
   input  logic [31:0]      redir_pc4,
   input  logic [15:0]      br_imm,
   input  logic [25:0]      jmp_idx,
   output logic [31:0]      inst_addr,
   input  logic [31:0]      inst,
   output logic [31:0]      id_pc,
   output logic [31:0]      id_pc4,
   output logic [31:0]      id_inst,
   output logic             id_valid,
   output logic [CNT_W-1:0] fetch_cnt,
   output logic             halted
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] br_target;
   logic [31:0] jmp_target;
   logic [31:0] redir_target;
   logic        redirect;

   assign inst_addr = pc;

   always_comb begin
      br_target    = redir_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
      jmp_target   = {redir_pc4[31:28], jmp_idx, 2'b00};
      redir_target = br_taken ? br_target : jmp_target;
      redirect     = br_taken | jmp_en;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         pc        <= RESET_PC;
         id_pc     <= '0;
         id_pc4    <= '0;
         id_inst   <= '0;
         id_valid  <= 1'b0;
         fetch_cnt <= '0;
         halted    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               id_valid <= 1'b0;
               if (start) state <= S_RUN;
            end
            S_RUN: begin
               // Redirect beats both the limit check and stall. A target past
               // the limit is caught by the limit check on the following edge.
               if (redirect) begin
                  pc       <= redir_target;
                  id_valid <= 1'b0;
                  id_inst  <= '0;
               end else if (pc >= PC_LIMIT) begin
                  state    <= S_HALT;
                  halted   <= 1'b1;
                  id_valid <= 1'b0;
               end else if (!stall) begin
                  id_pc    <= pc;
                  id_pc4   <= pc + 32'd4;
                  id_inst  <= inst;
                  id_valid <= 1'b1;
                  pc       <= pc + 32'd4;
                  if (fetch_cnt != {CNT_W{1'b1}}) fetch_cnt <= fetch_cnt + 1'b1;
               end
            end
            S_HALT: begin
               id_valid <= 1'b0;
               halted   <= 1'b1;
            end
            default: begin
               state    <= S_IDLE;
               id_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the MIPS CPU: owns the program counter, drives the 32-bit word address into the instruction memory, and registers the returned instruction into an IF/ID register for decode.
- Sits directly upstream of the instruction memory and downstream of the branch/jump resolution logic.
- Handles stall, branch/jump redirect with bubble insertion, program start/end control, and a fetched-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset; must be word aligned.
- PC_LIMIT, 32'h0000_0024, first byte address beyond the loaded program; fetch halts when PC reaches it.
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level; begins fetching from IDLE.
- stall  input  1  hold PC and IF/ID contents this cycle.
- br_taken  input  1  conditional branch resolved taken.
- jmp_en  input  1  unconditional jump (j format).
- redir_pc4  input  32  PC+4 of the redirecting instruction.
- br_imm  input  16  branch immediate; word offset, signed.
- jmp_idx  input  26  jump target index.
- inst_addr  output  32  byte address to instruction memory; memory indexes with bits [6:2].
- inst  input  32  instruction word returned combinationally by the memory.
- id_pc  output  32  PC of the instruction in IF/ID.
- id_pc4  output  32  id_pc + 4.
- id_inst  output  32  registered instruction.
- id_valid  output  1  IF/ID holds a real instruction.
- fetch_cnt  output  CNT_W  count of valid instructions captured; saturating.
- halted  output  1  high in HALT state.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=IDLE.
  - id_pc=0, id_pc4=0, id_inst=0, id_valid=0, fetch_cnt=0, halted=0.
  - Reset asserted mid-run aborts immediately; no partial update survives.
- inst_addr = pc, combinational from the pc register. Zero-cycle memory latency, so inst corresponds to pc in the same cycle.
- Targets:
  - br_target = redir_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00}, 32-bit wraparound.
  - jmp_target = {redir_pc4[31:28], jmp_idx, 2'b00}.
  - If br_taken and jmp_en are both high, br_taken wins.
  - Targets are always word aligned by construction.
- States:
  - IDLE: pc holds, id_valid=0. start=1 -> RUN at the next edge; the first capture occurs on the edge after that.
  - RUN: per-edge priority below.
  - HALT: sticky until reset. pc and IF/ID hold except id_valid=0; start, stall and redirects are ignored.
- Per-edge priority in RUN:
  - 1) Redirect (br_taken|jmp_en): pc<=target; id_valid<=0, id_inst<=0 (bubble); this overrides stall. If the target >= PC_LIMIT, the next edge enters HALT.
  - 2) Else if pc >= PC_LIMIT (unsigned): state<=HALT, id_valid<=0, pc holds.
  - 3) Else if stall: pc, id_pc, id_pc4, id_inst, id_valid all hold.
  - 4) Else: id_pc<=pc, id_pc4<=pc+4, id_inst<=inst, id_valid<=1, pc<=pc+4.
- fetch_cnt increments on every edge that sets id_valid via rule 4 and saturates at all-ones.
- pc+4 wraps mod 2^32. No exception is raised.
- halted is registered and equals (state==HALT).

Test Plan:
- Reset then start=1 with a 9-word program loaded: id_inst sequence 0x00002820, 0x8CB10000, 0x8CB20004 … on consecutive cycles; id_pc=0x0,0x4,0x8; fetch_cnt increments by 1 each.
- stall=1 for 3 cycles while pc=0x0C: inst_addr stays 0x0C, id_inst stays 0x8CB20004, fetch_cnt unchanged; resumes with 0x02329822.
- br_taken=1, redir_pc4=0x1C, br_imm=0x0002: next pc=0x24, id_valid=0 next cycle, then HALT with halted=1 and fetch_cnt frozen.
- jmp_en=1, redir_pc4=0x10, jmp_idx=26'h1 together with stall=1: pc<=0x04 (redirect beats stall), bubble inserted, then 0x8CB10000 captured.
- Sequential run to pc=0x24 with no redirect: exactly 9 valid captures, fetch_cnt=9, halted=1; start toggling afterwards has no effect.
- rst_n pulsed low mid-RUN at pc=0x14: all outputs zero asynchronously, pc=0, state IDLE; no fetch occurs until start is reasserted.
